// File: rtl/video_timing_decoder.sv
// video_timing_decoder: rebuilds de/x/y from the hs/vs/hb/vb pixel stream,
// measures line and frame geometry, and reports when that geometry is stable.
module video_timing_decoder #(
    parameter int H_W         = 10,
    parameter int V_W         = 9,
    parameter int LOCK_FRAMES = 2
) (
    input  logic           clk_sys,
    input  logic           reset_n,
    input  logic           ce_pix,
    input  logic           hs,
    input  logic           vs,
    input  logic           hb,
    input  logic           vb,
    output logic           de,
    output logic [H_W-1:0] x,
    output logic [V_W-1:0] y,
    output logic           line_start,
    output logic           frame_start,
    output logic [H_W-1:0] h_total,
    output logic [H_W-1:0] h_active,
    output logic [H_W-1:0] hs_width,
    output logic [V_W-1:0] v_total,
    output logic [V_W-1:0] v_active,
    output logic [V_W-1:0] vs_width,
    output logic           locked
);
    localparam logic [H_W-1:0] H_MAX = '1;
    localparam logic [V_W-1:0] V_MAX = '1;

    typedef enum logic [1:0] {UNLOCKED, COUNTING, LOCKED} state_t;

    state_t         state, state_nx;
    logic [3:0]     match_cnt, match_cnt_nx;
    logic           prev_hs, prev_vs, primed, line_de;
    logic [H_W-1:0] hc, act_acc, hsw_acc, prev_ht;
    logic [V_W-1:0] vc, vact_acc, vsw_acc, prev_vt;
    logic           hs_fall, vs_fall, cur_de, line_any, timeout, match;
    logic [H_W-1:0] ht_nx, ha_nx, hw_nx;
    logic [V_W-1:0] vc_cl, va_cl, vw_cl;

    function automatic logic [H_W-1:0] inc_h(input logic [H_W-1:0] v, input logic en);
        return (en && v != H_MAX) ? v + H_W'(1) : v;
    endfunction

    function automatic logic [V_W-1:0] inc_v(input logic [V_W-1:0] v, input logic en);
        return (en && v != V_MAX) ? v + V_W'(1) : v;
    endfunction

    // No edge can be seen until one sample has been taken since reset
    always_comb begin
        hs_fall  = ce_pix & primed & prev_hs & ~hs;
        vs_fall  = ce_pix & primed & prev_vs & ~vs;
        cur_de   = ~hb & ~vb;
        line_any = line_de | cur_de;
        timeout  = ce_pix & ~hs_fall & (hc == H_MAX);
        ht_nx    = timeout ? '0 : hs_fall ? inc_h(hc, 1'b1) : h_total;
        ha_nx    = timeout ? '0 : hs_fall ? inc_h(act_acc, ~hb) : h_active;
        hw_nx    = timeout ? '0 : hs_fall ? inc_h(hsw_acc, ~hs) : hs_width;
        vc_cl    = inc_v(vc, hs_fall);
        va_cl    = inc_v(vact_acc, hs_fall & line_any);
        vw_cl    = inc_v(vsw_acc, hs_fall & ~vs);
        match    = (ht_nx == prev_ht) && (vc_cl == prev_vt);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            prev_hs     <= 1'b1;
            prev_vs     <= 1'b1;
            primed      <= 1'b0;
            line_de     <= 1'b0;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            hc          <= '0;
            act_acc     <= '0;
            hsw_acc     <= '0;
            h_total     <= '0;
            h_active    <= '0;
            hs_width    <= '0;
            vc          <= '0;
            vact_acc    <= '0;
            vsw_acc     <= '0;
            v_total     <= '0;
            v_active    <= '0;
            vs_width    <= '0;
            prev_ht     <= '0;
            prev_vt     <= '0;
        end else begin
            line_start  <= hs_fall;
            frame_start <= vs_fall;
            if (ce_pix) begin
                prev_hs  <= hs;
                prev_vs  <= vs;
                primed   <= 1'b1;
                de       <= cur_de;
                if (cur_de)
                    x <= line_de ? inc_h(x, 1'b1) : '0;
                y        <= vs_fall ? '0 : inc_v(y, hs_fall & line_any);
                line_de  <= line_any & ~hs_fall;
                hc       <= hs_fall ? '0 : inc_h(hc, 1'b1);
                act_acc  <= hs_fall ? '0 : inc_h(act_acc, ~hb);
                hsw_acc  <= hs_fall ? '0 : inc_h(hsw_acc, ~hs);
                h_total  <= ht_nx;
                h_active <= ha_nx;
                hs_width <= hw_nx;
                vc       <= vs_fall ? '0 : vc_cl;
                vact_acc <= vs_fall ? '0 : va_cl;
                vsw_acc  <= vs_fall ? '0 : vw_cl;
                if (vs_fall) begin
                    v_total  <= vc_cl;
                    v_active <= va_cl;
                    vs_width <= vw_cl;
                    prev_ht  <= ht_nx;
                    prev_vt  <= vc_cl;
                end
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state     <= UNLOCKED;
            match_cnt <= '0;
        end else begin
            state     <= state_nx;
            match_cnt <= match_cnt_nx;
        end
    end

    // A timeout on the same sample as a frame close wins
    always_comb begin
        state_nx     = state;
        match_cnt_nx = match_cnt;
        if (vs_fall) begin
            match_cnt_nx = !match ? 4'd0 : (match_cnt == 4'hF) ? match_cnt : match_cnt + 4'd1;
            state_nx     = (match_cnt_nx >= 4'(LOCK_FRAMES)) ? LOCKED :
                           (match_cnt_nx != 4'd0) ? COUNTING : UNLOCKED;
        end
        if (timeout) begin
            state_nx     = UNLOCKED;
            match_cnt_nx = 4'd0;
        end
    end

    assign locked = (state == LOCKED);
endmodule
